sdram_bus_arbiter: RTL
======================

# sdram_bus_arbiter

Two-port round-robin arbiter sharing the single system-bus slave port of the SDRAM controller between two masters (e.g. the JTAG debug host and an on-chip memory tester). Forwards one single-beat read or write per cycle downstream with zero added latency. Tracks outstanding reads in an in-order tag FIFO so each returning read beat reaches the master that issued it.

## Interface
- AW, 23, address width (word address).
- DW, 16, data width; byte-enable width is DW/8.
- RD_DEPTH, 4, maximum outstanding reads (tag FIFO depth); power of two, at least 2.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pN_read, pN_write  in  1  port N (N=0,1) read/write request, held until accepted.
- pN_addr  in  AW  port N word address.
- pN_wdata  in  DW  port N write data.
- pN_byteenable  in  DW/8  port N byte enables.
- pN_ready  out  1  port N request accepted this cycle.
- pN_rvalid  out  1  read-data beat for port N.
- pN_rdata  out  DW  read data, valid with pN_rvalid.
- m_read, m_write  out  1  downstream request to the SDRAM controller.
- m_addr  out  AW; m_wdata  out  DW; m_byteenable  out  DW/8  downstream request fields.
- m_ready  in  1  downstream accept.
- m_rvalid  in  1  downstream read beat, returned in issue order.
- m_rdata  in  DW  downstream read data.
- err_rvalid  out  1  sticky: m_rvalid arrived while no read was outstanding.

## Operation
- A request is accepted when it is asserted and granted, its pN_ready is high, and m_ready is high in the same cycle. pN_ready = granted and m_ready and (write, or tag FIFO not full).
- A master asserting both read and write is a protocol error. The read is forwarded; the write is ignored.
- Grant selection is combinational from the current requests, the lock register and the priority pointer.
  - If the lock is valid, the locked port is granted.
  - Otherwise, with exactly one port requesting, that port is granted.
  - Otherwise, with both requesting, the port named by prio is granted.
- Lock: if the granted port is requesting and is not accepted this cycle (m_ready low, or a read blocked by a full FIFO), set lock_valid and lock_id to that port. Clear the lock on acceptance. This guarantees the downstream request is never switched mid-wait.
- Priority: on every accept from port X, set prio to the other port. Reset value of prio is 0.
- Read blocking: if the FIFO is full and the granted port requests a read, m_read stays low and the port stays locked until a pop frees a slot. Writes are never blocked by the FIFO. A locked blocked read still blocks the other port; this is required for fairness.
- Tag FIFO:
  - Push the granted port ID on each accepted read.
  - Pop on m_rvalid; route m_rdata to the port at the head: pN_rvalid = m_rvalid and head==N, pN_rdata = m_rdata for both ports.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers are log2(RD_DEPTH) bits and wrap modulo RD_DEPTH. Count is log2(RD_DEPTH)+1 bits, range 0..RD_DEPTH.
- m_rvalid with count==0: set err_rvalid (cleared only by reset), drop the beat, assert no pN_rvalid, leave pointers unchanged.
- m_addr, m_wdata and m_byteenable mux from the granted port. They are don't-care when m_read and m_write are low, but are driven from port 0 when idle.

## Timing
- Request path is combinational, with zero cycles from port to m_*. The pN_ready path is combinational from m_ready.
- Read return path is combinational, with zero cycles from m_rvalid to pN_rvalid. There is no combinational path from m_rvalid to pN_ready; FIFO full is evaluated on registered count only.
- Registered state: lock_valid, lock_id, prio, FIFO pointers/count/storage, err_rvalid.
- Reset values:
  - Registers: lock_valid=0, prio=0, count=0, pointers=0, err_rvalid=0.
  - Outputs follow from these. With no requests and no m_rvalid, all m_read/m_write/pN_ready/pN_rvalid are 0 and err_rvalid is 0.
- Reset asserted mid-transaction discards all outstanding read tags. Beats returning afterwards set err_rvalid; the controller must be reset together with the arbiter.
- Maximum throughput is one accepted request per cycle. Under constant contention with m_ready=1, grants alternate 0,1,0,1.

## Test plan
- Single port: port 0 writes addr 0x000010 data 0xA5A5, then reads it with m_ready=1 and a model SDRAM with 3-cycle read latency -> p0_ready pulses once per request, p0_rvalid one cycle with 0xA5A5, p1_rvalid stays 0.
- Contention: both ports request writes every cycle for 8 cycles, m_ready=1 -> m_addr alternates p0,p1,p0,… starting with port 0 after reset; each port accepted 4 times.
- Lock: port 1 reads while m_ready=0 for 5 cycles, port 0 raises a write in cycle 2 -> m_addr stays port 1 for all 5 cycles; port 1 accepted when m_ready rises; port 0 granted next cycle.
- Read routing: interleave reads p0@0x1, p1@0x2, p0@0x3, p1@0x4 with 4-cycle latency -> returns in order to ports 0,1,0,1 with matching data; count returns to 0.
- FIFO full: RD_DEPTH=4, issue 4 reads with m_rvalid held off -> 5th read sees p*_ready=0 and m_read=0 while a write from the other port is also blocked by the lock; first m_rvalid frees a slot and the read is accepted the next cycle.
- Errors/reset: m_rvalid with no outstanding reads -> err_rvalid=1 and stays 1, no pN_rvalid. Assert rst_n low with 2 reads outstanding -> count=0, err_rvalid=0, lock cleared.

Source files
------------

// File: rtl/sdram_bus_arbiter.sv
// sdram_bus_arbiter
// Shares the single system-bus slave port of the SDRAM controller between two
// masters. One single-beat read or write is forwarded per cycle with no added
// latency. Grants are round-robin and locked while a request waits. Outstanding
// reads are tracked in an in-order tag FIFO so each returning beat is steered
// back to the master that issued it.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   pN_read_i / pN_write_i       port N request, held until pN_ready_o
//   pN_addr_i / pN_wdata_i / pN_byteenable_i   port N request fields
//   pN_ready_o                   port N request accepted this cycle
//   pN_rvalid_o / pN_rdata_o     read beat returned to port N
//   m_read_o / m_write_o / m_addr_o / m_wdata_o / m_byteenable_o  downstream request
//   m_ready_i                    downstream accept
//   m_rvalid_i / m_rdata_i       downstream read beat, in issue order
//   err_rvalid_o                 sticky: read beat arrived with nothing outstanding
module sdram_bus_arbiter #(
  parameter int AW       = 23,
  parameter int DW       = 16,
  parameter int RD_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_read_i,
  input  logic            p0_write_i,
  input  logic [AW-1:0]   p0_addr_i,
  input  logic [DW-1:0]   p0_wdata_i,
  input  logic [DW/8-1:0] p0_byteenable_i,
  output logic            p0_ready_o,
  output logic            p0_rvalid_o,
  output logic [DW-1:0]   p0_rdata_o,
  input  logic            p1_read_i,
  input  logic            p1_write_i,
  input  logic [AW-1:0]   p1_addr_i,
  input  logic [DW-1:0]   p1_wdata_i,
  input  logic [DW/8-1:0] p1_byteenable_i,
  output logic            p1_ready_o,
  output logic            p1_rvalid_o,
  output logic [DW-1:0]   p1_rdata_o,
  output logic            m_read_o,
  output logic            m_write_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [DW-1:0]   m_wdata_o,
  output logic [DW/8-1:0] m_byteenable_o,
  input  logic            m_ready_i,
  input  logic            m_rvalid_i,
  input  logic [DW-1:0]   m_rdata_i,
  output logic            err_rvalid_o
);

  localparam int            PW       = $clog2(RD_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(RD_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic          lock_valid_q, lock_valid_d;
  logic          lock_id_q, lock_id_d;
  logic          prio_q, prio_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [RD_DEPTH-1:0] tag_q, tag_d;
  logic          err_q, err_d;

  logic req0_s, req1_s, gnt_s, gnt_req_s, gnt_rd_s, src1_s;
  logic fifo_full_s, accept_s, push_s, beat_s, head_s;

  // Grant selection: lock first, then a sole requester, then the priority pointer.
  always_comb begin
    req0_s = p0_read_i | p0_write_i;
    req1_s = p1_read_i | p1_write_i;
    gnt_s  = 1'b0;
    if (lock_valid_q) begin
      gnt_s = lock_id_q;
    end else if (req0_s && req1_s) begin
      gnt_s = prio_q;
    end else if (req1_s) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    gnt_req_s = gnt_s ? req1_s : req0_s;
    // Read wins when a master raises both; the write half is ignored.
    gnt_rd_s  = gnt_s ? p1_read_i : p0_read_i;
  end

  // Fullness uses the registered count only, so m_rvalid never reaches pN_ready.
  assign fifo_full_s = (count_q == FULL_CNT);
  assign accept_s    = gnt_req_s & m_ready_i & (~gnt_rd_s | ~fifo_full_s);
  assign push_s      = accept_s & gnt_rd_s;
  assign head_s      = tag_q[rd_ptr_q];
  // A beat is only meaningful when a tag is outstanding; otherwise it is dropped.
  assign beat_s      = m_rvalid_i & (count_q != CNT_ZERO);
  // Request fields come from port 0 unless port 1 is granted and requesting.
  assign src1_s      = gnt_req_s & gnt_s;

  // Downstream request and per-port handshake/return outputs.
  always_comb begin
    m_read_o       = gnt_req_s & gnt_rd_s & ~fifo_full_s;
    m_write_o      = gnt_req_s & ~gnt_rd_s;
    m_addr_o       = src1_s ? p1_addr_i       : p0_addr_i;
    m_wdata_o      = src1_s ? p1_wdata_i      : p0_wdata_i;
    m_byteenable_o = src1_s ? p1_byteenable_i : p0_byteenable_i;
    p0_ready_o     = accept_s & ~gnt_s;
    p1_ready_o     = accept_s & gnt_s;
    p0_rvalid_o    = beat_s & ~head_s;
    p1_rvalid_o    = beat_s & head_s;
    p0_rdata_o     = m_rdata_i;
    p1_rdata_o     = m_rdata_i;
    err_rvalid_o   = err_q;
  end

  // Next state for lock, priority, tag FIFO and the sticky error flag.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    prio_d       = prio_q;
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_d        = err_q;

    // Hold the grant on a waiting requester so m_* never switches mid-wait.
    if (gnt_req_s && !accept_s) begin
      lock_valid_d = 1'b1;
      lock_id_d    = gnt_s;
    end else if (accept_s) begin
      lock_valid_d = 1'b0;
    end else begin
      lock_valid_d = lock_valid_q;
    end

    if (accept_s) begin
      prio_d = ~gnt_s;
    end else begin
      prio_d = prio_q;
    end

    if (push_s) begin
      tag_d[wr_ptr_q] = gnt_s;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (beat_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, beat_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (m_rvalid_i && (count_q == CNT_ZERO)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      prio_q       <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      prio_q       <= prio_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

endmodule
